// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter and sequencer sharing one registered adder among N_REQ requesters.
// Issues one operation per cycle and returns each result to its owner via a tag pipeline.
module adder_rr_arbiter #(
    parameter int NB_BITS = 16,
    parameter int N_REQ   = 4,
    parameter int LAT     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           i_req_valid,
    output logic [N_REQ-1:0]           o_req_ready,
    input  logic [N_REQ*NB_BITS-1:0]   i_req_a,
    input  logic [N_REQ*NB_BITS-1:0]   i_req_b,
    input  logic [N_REQ-1:0]           i_req_cin,
    output logic [NB_BITS-1:0]         o_add_a,
    output logic [NB_BITS-1:0]         o_add_b,
    output logic                       o_add_cin,
    input  logic [NB_BITS-1:0]         i_add_sum,
    input  logic                       i_add_cout,
    output logic [N_REQ-1:0]           o_rsp_valid,
    output logic [NB_BITS:0]           o_rsp_sum,
    output logic                       o_busy
);

    localparam int                PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0]    N_REQ_EXT = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(N_REQ - 1);

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] owner;
    } tag_t;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic [PTR_W:0]     cand;
    logic [NB_BITS-1:0] sel_a;
    logic [NB_BITS-1:0] sel_b;
    logic               sel_cin;
    logic [N_REQ-1:0]   rsp_onehot;
    logic               tags_busy;
    tag_t               tag_q [LAT+1];

    // Scan ptr, ptr+1, ... modulo N_REQ; the first valid requester wins.
    // NOTE: blocking assignments here are intentional -- cand and grant_any are
    // scratch values re-evaluated on every loop pass, and every variable gets a
    // default first so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(off);
            if (cand >= N_REQ_EXT) cand = cand - N_REQ_EXT;
            if (!grant_any && i_req_valid[cand[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (grant_any) o_req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (o_req_ready[i]) begin
                sel_a   = i_req_a[i*NB_BITS +: NB_BITS];
                sel_b   = i_req_b[i*NB_BITS +: NB_BITS];
                sel_cin = i_req_cin[i];
            end
        end
    end

    always_comb begin
        rsp_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_onehot[i] = tag_q[LAT].valid && (tag_q[LAT].owner == PTR_W'(i));
        end
    end

    always_comb begin
        tags_busy = 1'b0;
        for (int s = 0; s <= LAT; s++) begin
            tags_busy = tags_busy | tag_q[s].valid;
        end
    end

    assign o_busy = tags_busy | (|o_rsp_valid);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            o_add_a   <= '0;
            o_add_b   <= '0;
            o_add_cin <= 1'b0;
        end else if (grant_any) begin
            ptr       <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            o_add_a   <= sel_a;
            o_add_b   <= sel_b;
            o_add_cin <= sel_cin;
        end
    end

    // Stage LAT lines up with the cycle in which the adder output reflects that issue.
    // NOTE: the tag array is reset (unlike a datapath memory) because its valid
    // bits must drop every in-flight operation when reset arrives mid-flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= LAT; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= '{valid: grant_any, owner: grant_idx};
            for (int s = 1; s <= LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rsp_valid <= '0;
            o_rsp_sum   <= '0;
        end else begin
            o_rsp_valid <= rsp_onehot;
            if (tag_q[LAT].valid) o_rsp_sum <= {i_add_cout, i_add_sum};
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with a behavioural registered ripple adder (a+b+cin)
// attached beside it; responses are logged at the falling edge and compared to a reference.
module tb_adder_rr_arbiter;

    localparam int NB  = 16;
    localparam int NR  = 4;
    localparam int LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*NB-1:0]  req_a;
    logic [NR*NB-1:0]  req_b;
    logic [NR-1:0]     req_cin;
    logic [NB-1:0]     add_a;
    logic [NB-1:0]     add_b;
    logic              add_cin;
    logic [NB-1:0]     add_sum;
    logic              add_cout;
    logic [NR-1:0]     rsp_valid;
    logic [NB:0]       rsp_sum;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          c;
        logic [3:0]  v;
        logic [16:0] s;
    } rsp_t;
    rsp_t rsp_q[$];

    logic [NB:0] add_pipe [LAT];

    adder_rr_arbiter #(.NB_BITS(NB), .N_REQ(NR), .LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_cin   (req_cin),
        .o_add_a     (add_a),
        .o_add_b     (add_b),
        .o_add_cin   (add_cin),
        .i_add_sum   (add_sum),
        .i_add_cout  (add_cout),
        .o_rsp_valid (rsp_valid),
        .o_rsp_sum   (rsp_sum),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered adder model with LAT stages.
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_sum  = add_pipe[LAT-1][NB-1:0];
    assign add_cout = add_pipe[LAT-1][NB];

    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic c);
        return {1'b0, a} + {1'b0, b} + {16'b0, c};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic c);
        req_a[i*NB +: NB] = a;
        req_b[i*NB +: NB] = b;
        req_cin[i]        = c;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
            check("rsp_onehot0", 64'($onehot0(rsp_valid)), 64'd1);
        end
        if (rsp_valid !== '0) rsp_q.push_back('{c: cyc, v: rsp_valid, s: rsp_sum});
    end

    initial begin
        int          c0;
        int          exp_g [5];
        logic [3:0]  masks [5];
        logic [15:0] ea;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;

        // Reset held for 5 cycles, then 10 idle cycles.
        repeat (5) begin
            @(negedge clk);
            check("reset_outs", {add_a, add_b, add_cin, rsp_valid, rsp_sum, busy, req_ready}, '0);
        end
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            check("idle_outs", {add_a, add_b, add_cin, rsp_valid, rsp_sum, busy, req_ready}, '0);
        end
        check("idle_no_rsp", 64'(rsp_q.size()), 64'd0);

        // Full contention: grants rotate 0,1,2,3,0,1,2,3.
        for (int i = 0; i < NR; i++) set_ops(i, 16'(32'h1000 * i), 16'h0F0F, i[0]);
        req_valid = 4'hF;
        #1;
        for (int j = 0; j < 8; j++) begin
            check("cont_grant", 64'(req_ready), 64'(4'b0001 << (j % 4)));
            tick();
            check("cont_busy", 64'(busy), 64'd1);
        end
        req_valid = '0;
        repeat (2) begin
            tick();
            check("cont_busy_drain", 64'(busy), 64'd1);
        end
        tick();
        check("cont_idle", {busy, rsp_valid}, '0);
        check("cont_rsp_count", 64'(rsp_q.size()), 64'd8);
        if (rsp_q.size() == 8) begin
            c0 = rsp_q[0].c;
            for (int j = 0; j < 8; j++) begin
                check("cont_rsp_owner", 64'(rsp_q[j].v), 64'(4'b0001 << (j % 4)));
                check("cont_rsp_sum", 64'(rsp_q[j].s),
                      64'(ref_add(16'(32'h1000 * (j % 4)), 16'h0F0F, (j % 2) == 1)));
                check("cont_rsp_cycle", 64'(rsp_q[j].c - c0), 64'(j));
            end
        end
        rsp_q.delete();

        // Single request from requester 1 (ptr is back at 0).
        set_ops(1, 16'hFFFF, 16'h0001, 1'b0);
        req_valid = 4'b0010;
        #1;
        check("single_grant", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        check("single_issue", {add_a, add_b, add_cin, busy}, {16'hFFFF, 16'h0001, 1'b0, 1'b1});
        tick();
        check("single_rsp_early", 64'(rsp_valid), 64'd0);
        tick();
        check("single_rsp", {rsp_valid, rsp_sum}, {4'b0010, 17'h10000});
        tick();
        check("single_done", {rsp_valid, busy}, '0);
        check("single_rsp_count", 64'(rsp_q.size()), 64'd1);
        rsp_q.delete();

        // Pointer skip and wrap: ptr is 2, only 0 valid, then 0 and 2; finally all
        // valid to confirm ptr landed on 3.
        for (int i = 0; i < NR; i++) set_ops(i, 16'(32'hA000 + i), 16'h7000, 1'b1);
        exp_g = '{0, 2, 0, 2, 3};
        masks = '{4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b1111};
        for (int j = 0; j < 5; j++) begin
            req_valid = masks[j];
            #1;
            check("skip_grant", 64'(req_ready), 64'(4'b0001 << exp_g[j]));
            tick();
        end
        req_valid = '0;
        repeat (3) tick();
        check("skip_rsp_count", 64'(rsp_q.size()), 64'd5);
        if (rsp_q.size() == 5) begin
            for (int j = 0; j < 5; j++) begin
                ea = 16'(32'hA000 + exp_g[j]);
                check("skip_rsp_owner", 64'(rsp_q[j].v), 64'(4'b0001 << exp_g[j]));
                check("skip_rsp_sum", 64'(rsp_q[j].s), 64'(ref_add(ea, 16'h7000, 1'b1)));
            end
        end
        rsp_q.delete();

        // Back-to-back single requester 3 (ptr is 0).
        for (int i = 0; i < 6; i++) begin
            set_ops(3, 16'(i), 16'(2 * i), 1'b1);
            req_valid = 4'b1000;
            #1;
            check("b2b_grant", 64'(req_ready), 64'h8);
            tick();
        end
        req_valid = '0;
        repeat (3) tick();
        check("b2b_rsp_count", 64'(rsp_q.size()), 64'd6);
        if (rsp_q.size() == 6) begin
            c0 = rsp_q[0].c;
            for (int j = 0; j < 6; j++) begin
                check("b2b_rsp", {rsp_q[j].v, rsp_q[j].s}, {4'b1000, 17'(3 * j + 1)});
                check("b2b_rsp_cycle", 64'(rsp_q[j].c - c0), 64'(j));
            end
        end
        rsp_q.delete();

        // Reset mid-flight: two accepted requests are dropped.
        set_ops(0, 16'h1234, 16'h1111, 1'b0);
        set_ops(1, 16'h4321, 16'h2222, 1'b1);
        req_valid = 4'b0001;
        #1;
        check("mid_grant0", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b0010;
        #1;
        check("mid_grant1", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("mid_reset_outs", {add_a, add_b, add_cin, rsp_valid, rsp_sum, busy}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check("mid_idle", {rsp_valid, busy}, '0);
        end
        check("mid_no_rsp", 64'(rsp_q.size()), 64'd0);
        req_valid = 4'hF;
        #1;
        check("mid_first_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        repeat (4) tick();
        rsp_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Round-robin arbiter and sequencer that shares one registered adder (rca, bcla or hierarchicalcsa) among N_REQ requesters. It accepts operand requests over a valid/ready handshake, issues one operation per cycle to the adder through registered operand ports, and tracks each in-flight operation with a tag pipeline. It returns each result to its owner with a one-hot response strobe. It sits between the requesting datapath units and the adder instance, which is instantiated beside it at the same level.

## Interface
- NB_BITS, 16, operand width; the adder result is NB_BITS+1 bits wide.
- N_REQ, 4, number of requesters (2..8).
- LAT, 1, register latency of the attached adder, in cycles (1..4).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  N_REQ  per-requester request valid.
- o_req_ready  out  N_REQ  one-hot grant; a transfer occurs when valid[i] & ready[i] is high at a clk edge.
- i_req_a  in  N_REQ*NB_BITS  operand A; requester i occupies bits [i*NB_BITS +: NB_BITS].
- i_req_b  in  N_REQ*NB_BITS  operand B, same packing as i_req_a.
- i_req_cin  in  N_REQ  carry-in per requester.
- o_add_a  out  NB_BITS  registered operand A to the adder.
- o_add_b  out  NB_BITS  registered operand B to the adder.
- o_add_cin  out  1  registered carry-in to the adder.
- i_add_sum  in  NB_BITS  adder sum output.
- i_add_cout  in  1  adder carry-out.
- o_rsp_valid  out  N_REQ  one-hot strobe, one cycle wide, marking the owner of o_rsp_sum.
- o_rsp_sum  out  NB_BITS+1  registered result, {cout, sum}.
- o_busy  out  1  high while any tag-pipeline stage or the response register holds a valid entry.

## Operation
- Arbitration:
  - o_req_ready is combinational from i_req_valid and ptr.
  - The grant goes to the first valid requester found scanning ptr, ptr+1, … modulo N_REQ.
  - o_req_ready is all-zero when no request is valid.
  - At most one ready bit is high at any time.
- Pointer update:
  - ptr is a log2(N_REQ)-bit register, reset to 0.
  - On a transfer by requester g, ptr <= (g+1) mod N_REQ, wrapping from N_REQ-1 to 0.
  - Without a transfer, ptr holds.
- Issue:
  - On a transfer, o_add_a/o_add_b/o_add_cin <= the granted requester's operands.
  - Otherwise these outputs hold their last value and are not cleared.
- Tag pipeline:
  - LAT+1 stages; each stage holds {valid, owner index}.
  - Stage 0 loads {transfer, g} every cycle; the entry shifts by one stage per cycle.
  - The output stage aligns with the cycle in which i_add_sum/i_add_cout reflect that issue.
- Response:
  - When the output-stage entry is valid, o_rsp_valid <= onehot(owner) and o_rsp_sum <= {i_add_cout, i_add_sum}.
  - Otherwise o_rsp_valid <= 0 and o_rsp_sum holds.
- Responses are never back-pressured.
- Results return in issue order.
- Throughput is 1 operation per cycle.
- A requester may change its operands or drop valid freely before the transfer; nothing is committed until the transfer.

## Timing
- Reset values: o_add_*, o_rsp_sum and o_rsp_valid are 0; ptr is 0; all tag stages are invalid; o_busy is 0.
- o_req_ready is 0 during reset because ptr=0 and it depends only on valid; the bench holds valid low during reset.
- Latency for a transfer at edge k:
  - o_add_* update at edge k.
  - The adder result is valid after edge k+LAT.
  - o_rsp_valid is high for exactly the cycle following edge k+LAT+1, i.e. LAT+1 edges after acceptance.
  - With LAT=1, this is the cycle after edge k+2.
- Simultaneous events: a new transfer and a response in the same cycle are independent and both occur.
- Reset mid-operation:
  - All in-flight entries are dropped and no response is produced for them.
  - After release, ptr=0 and the outputs are at their reset values.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0; no requester waits more than N_REQ-1 cycles.

## Test plan
All scenarios use defaults (NB_BITS=16, N_REQ=4, LAT=1), with rca as the attached adder and a bench-side reference model (a+b+cin).

- Reset check: hold rst_n low for 5 cycles with requests idle, then release and stay idle for 10 cycles -> all outputs 0 throughout, o_rsp_valid never set, o_busy 0.
- Single request: requester 1 sends a=16'hFFFF, b=16'h0001, cin=0, accepted at edge k -> o_rsp_valid=4'b0010 and o_rsp_sum=17'h10000 in the cycle after edge k+2; no other strobes.
- Full contention: all four requesters valid for 8 cycles, with requester i sending a=16'h1000*i, b=16'h0F0F, cin=i[0] -> grants 0,1,2,3,0,1,2,3; 8 consecutive responses in the same order, each matching the reference model; o_busy high until the last response.
- Pointer skip and wrap: requester 0 is granted first, then only 0 and 2 stay valid -> grant sequence 0,2,0,2; ptr values 1,3,1,3.
- Back-to-back single requester: requester 3 continuously valid for 6 cycles with a=i, b=2*i, cin=1 (i=0..5) -> 6 accepts on consecutive edges; 6 consecutive responses with o_rsp_sum=3*i+1; no idle gap.
- Reset mid-flight: accept requests from requesters 0 and 1 on consecutive edges, then assert rst_n low for 1 cycle -> no response strobes for either request; after release the first grant with all requesters valid goes to requester 0.
